// File: rtl/input_conditioner.sv
// input_conditioner
// Board-input front end: synchronises and debounces the stop button, the
// Debug_DM slide switch and the program switch bus, and emits single-cycle
// stop_press / switch_changed pulses. Runs on the undivided board clock.
//
// Build option: define STOP_TOGGLE_EN to make `stop` a press-to-toggle latch.
// With it undefined, `stop` is the debounced button level itself.
//
// Channel bit map inside the packed vectors:
//   bit 0          stop button
//   bit 1          debug switch
//   bits SW_W+1:2  program switches
module input_conditioner #(
   parameter int SW_W            = 10,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic            clk_board,
   input  logic            rst_n,
   input  logic            stop_raw,
   input  logic            debug_raw,
   input  logic [SW_W-1:0] switch_raw,
   output logic            stop,
   output logic            Debug_DM,
   output logic [SW_W-1:0] switch_in,
   output logic            stop_press,
   output logic            switch_changed
);

   localparam int NCH = SW_W + 2;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [NCH-1:0]  raw_vec;

   logic [NCH-1:0]  s1_q, s1_d;
   logic [NCH-1:0]  s2_q, s2_d;
   logic [NCH-1:0]  q_q, q_d;
   logic [CW-1:0]   cnt_q [NCH];
   logic [CW-1:0]   cnt_d [NCH];

   // Delayed copies of the accepted levels, used to spot a q update one
   // cycle after it happens so the pulses follow the level by one cycle.
   logic            stop_dly_q, stop_dly_d;
   logic [SW_W-1:0] sw_dly_q, sw_dly_d;

   logic            stop_press_q, stop_press_d;
   logic            switch_changed_q, switch_changed_d;

`ifdef STOP_TOGGLE_EN
   logic            stop_latch_q, stop_latch_d;
`endif

   assign raw_vec = {switch_raw, debug_raw, stop_raw};

   // Next-state logic: synchroniser shift, per-channel debounce counters,
   // and edge detection on the accepted levels.
   always_comb begin
      s1_d = raw_vec;
      s2_d = s1_q;
      q_d  = q_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != q_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               q_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end

      stop_dly_d       = q_q[0];
      sw_dly_d         = q_q[NCH-1:2];
      stop_press_d     = q_q[0] & ~stop_dly_q;
      switch_changed_d = |(q_q[NCH-1:2] ^ sw_dly_q);

`ifdef STOP_TOGGLE_EN
      stop_latch_d = stop_latch_q ^ stop_press_d;
`endif
   end

   // State registers; a low rst_n at a clock edge clears every flop so a
   // level held through reset must be debounced again from scratch.
   always_ff @(posedge clk_board) begin
      if (!rst_n) begin
         s1_q             <= '0;
         s2_q             <= '0;
         q_q              <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
         stop_dly_q       <= 1'b0;
         sw_dly_q         <= '0;
         stop_press_q     <= 1'b0;
         switch_changed_q <= 1'b0;
`ifdef STOP_TOGGLE_EN
         stop_latch_q     <= 1'b0;
`endif
      end else begin
         s1_q             <= s1_d;
         s2_q             <= s2_d;
         q_q              <= q_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stop_dly_q       <= stop_dly_d;
         sw_dly_q         <= sw_dly_d;
         stop_press_q     <= stop_press_d;
         switch_changed_q <= switch_changed_d;
`ifdef STOP_TOGGLE_EN
         stop_latch_q     <= stop_latch_d;
`endif
      end
   end

   assign Debug_DM       = q_q[1];
   assign switch_in      = q_q[NCH-1:2];
   assign stop_press     = stop_press_q;
   assign switch_changed = switch_changed_q;

`ifdef STOP_TOGGLE_EN
   assign stop = stop_latch_q;
`else
   assign stop = q_q[0];
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// Drives the conditioner one board-clock cycle at a time with DEBOUNCE_CYCLES=4.
// Every cycle the expected outputs are pushed onto a scoreboard queue as the
// stimulus is driven, then popped and compared once the DUT has clocked.
// Expected waveforms come from the documented timing: a raw change captured
// at call 1 shows on the conditioned level at call 6 and on pulses at call 7.
module tb_input_conditioner;

   localparam int SW_W = 10;
   localparam int DC   = 4;

`ifdef STOP_TOGGLE_EN
   localparam bit TOG = 1'b1;
`else
   localparam bit TOG = 1'b0;
`endif

   logic            clk_board = 1'b0;
   logic            rst_n;
   logic            stop_raw;
   logic            debug_raw;
   logic [SW_W-1:0] switch_raw;
   logic            stop;
   logic            Debug_DM;
   logic [SW_W-1:0] switch_in;
   logic            stop_press;
   logic            switch_changed;

   int   vecCount  = 0;
   int   missCount = 0;
   logic tog       = 1'b0;

   typedef struct {
      string       tag;
      logic [13:0] expv;
   } exp_t;

   exp_t sb[$];

   input_conditioner #(
      .SW_W(SW_W),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk_board(clk_board),
      .rst_n(rst_n),
      .stop_raw(stop_raw),
      .debug_raw(debug_raw),
      .switch_raw(switch_raw),
      .stop(stop),
      .Debug_DM(Debug_DM),
      .switch_in(switch_in),
      .stop_press(stop_press),
      .switch_changed(switch_changed)
   );

   // Free-running board clock
   always #5 clk_board = ~clk_board;

   // Hard time limit so a stuck run still ends with a report
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one packed output vector {stop, stop_press, Debug_DM, switch_changed, switch_in}
   task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] expv);
      vecCount++;
      if (got !== expv) begin
         missCount++;
         $display("[TB] FAIL %s @%0t: got stop=%b press=%b dbg=%b chg=%b sw=%03h, expected stop=%b press=%b dbg=%b chg=%b sw=%03h",
                  tag, $time, got[13], got[12], got[11], got[10], got[9:0],
                  expv[13], expv[12], expv[11], expv[10], expv[9:0]);
      end
   endtask

   // Drive one cycle of raw inputs, queue the outputs expected after the edge,
   // then clock and check against the popped expectation
   task automatic applyStimulus(input logic rst, input logic stp, input logic dbg,
                                input logic [SW_W-1:0] sw, input string tag,
                                input logic stopq, input logic press, input logic dbgq,
                                input logic [SW_W-1:0] swq, input logic chg);
      exp_t e;
      logic stopExp;
      rst_n      = rst;
      stop_raw   = stp;
      debug_raw  = dbg;
      switch_raw = sw;
      if (!rst) tog = 1'b0;
      else if (press) tog = ~tog;
      stopExp = TOG ? tog : stopq;
      e.tag  = tag;
      e.expv = {stopExp, (press & rst), (dbgq & rst), (chg & rst), (rst ? swq : 10'h000)};
      sb.push_back(e);
      @(posedge clk_board);
      #1;
      e = sb.pop_front();
      checkOutput(e.tag, {stop, stop_press, Debug_DM, switch_changed, switch_in}, e.expv);
   endtask

   initial begin
      logic [14:0] bounceBits;
      logic        bStp;
      logic        pStp;
      logic        sq;

      // Reset held three cycles with every raw input high
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, "reset_hold", 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);

      // Release: levels appear 6 edges later, pulses one cycle after that
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b1, 1'b1, 10'h3FF, "reset_release",
                       (i >= 6), (i == 7), (i >= 6), ((i >= 6) ? 10'h3FF : 10'h000), (i == 7));

      // Drop every input; levels fall after 6 edges, falling switches still pulse
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, "release_all",
                       (i < 6), 1'b0, (i < 6), ((i < 6) ? 10'h3FF : 10'h000), (i == 7));

      // Bouncy stop: 3 high, 1 low, 3 high, then low; never accepted
      bounceBits = 15'b000000001110111;
      for (int i = 0; i < 15; i++) begin
         bStp = bounceBits[i];
         applyStimulus(1'b1, bStp, 1'b0, 10'h000, "bounce_reject",
                       1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      end

      // Short reset so the stop latch starts from 0 for the press test
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, "reset_clear", 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);

      // Two clean 10-cycle presses separated by 10 low cycles
      for (int i = 1; i <= 40; i++) begin
         pStp = (i <= 10) || (i >= 21 && i <= 30);
         sq   = (i >= 6 && i <= 15) || (i >= 26 && i <= 35);
         applyStimulus(1'b1, pStp, 1'b0, 10'h000, "clean_press",
                       sq, (i == 7 || i == 27), 1'b0, 10'h000, 1'b0);
      end

      // Whole switch bus changes on one edge
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 10'h155, "switch_bus",
                       1'b0, 1'b0, 1'b0, ((i >= 6) ? 10'h155 : 10'h000), (i == 7));

      // Back to zero before the staggered test
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, "switch_clear",
                       1'b0, 1'b0, 1'b0, ((i >= 6) ? 10'h000 : 10'h155), (i == 7));

      // bit0 raised, bit9 raised two cycles later: two separate pulses
      for (int i = 1; i <= 12; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, ((i >= 3) ? 10'h201 : 10'h001), "switch_stagger",
                       1'b0, 1'b0, 1'b0,
                       ((i >= 8) ? 10'h201 : ((i >= 6) ? 10'h001 : 10'h000)),
                       (i == 7 || i == 9));

      // Stop and switches accepted on the same edge: both pulses together
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b1, 1'b0, 10'h0FF, "simultaneous",
                       (i >= 6), (i == 7), 1'b0, ((i >= 6) ? 10'h0FF : 10'h201), (i == 7));

      // Stop button released; no press pulse, toggle latch unaffected
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 10'h0FF, "stop_release",
                       (i < 6), 1'b0, 1'b0, 10'h0FF, 1'b0);

      // Debug raised, reset lands mid-count, raw held high afterwards
      for (int i = 1; i <= 3; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 10'h0FF, "midcount_pre",
                       1'b0, 1'b0, 1'b0, 10'h0FF, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 10'h0FF, "midcount_reset",
                    1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b1, 10'h0FF, "midcount_post",
                       1'b0, 1'b0, (i >= 6), ((i >= 6) ? 10'h0FF : 10'h000), (i == 7));

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
